tempo_tick: RTL and testbench

- Tempo/transport generator for the MusicPlayer; sits directly upstream of the beat counter (mod-4).
- Drives that counter's ena/inc/rst inputs from a programmable-period prescaler.
- Supports play/pause/stop transport control and an 8-step saturating tempo setting.
- The downstream counter's tc/cnt then advance the song position.

---
 rtl/mp_pkg.sv | 20 ++
 rtl/tempo_tick_if.sv | 26 ++
 rtl/tick_div.sv | 46 ++++
 rtl/tempo_tick.sv | 122 ++++++++++++
 tb/tb_tempo_tick.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mp_pkg.sv
// Shared types and helpers for the MusicPlayer tempo/transport path.
package mp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int TEMPO_W   = 3;
    localparam int TEMPO_MAX = 7;

    // Callers size the result down to their prescaler width.
    function automatic logic [31:0] period(input logic [TEMPO_W-1:0] tempo,
                                           input int unsigned base,
                                           input int unsigned step);
        return base - (32'(tempo) * step);
    endfunction

endpackage

// File: rtl/tempo_tick_if.sv
// Transport-control pulses in, beat-counter drive and status out.
interface tempo_tick_if;
    import mp_pkg::*;

    logic               play;
    logic               pause;
    logic               stop;
    logic               tempo_up;
    logic               tempo_dn;
    logic               ena;
    logic               inc;
    logic               cnt_clr;
    logic               playing;
    logic [TEMPO_W-1:0] tempo;

    modport master (
        output play, pause, stop, tempo_up, tempo_dn,
        input  ena, inc, cnt_clr, playing, tempo
    );

    modport slave (
        input  play, pause, stop, tempo_up, tempo_dn,
        output ena, inc, cnt_clr, playing, tempo
    );

endinterface

// File: rtl/tick_div.sv
// Programmable-period prescaler; emits one registered tick per period while running.
module tick_div #(
    parameter int DIV_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             tick,
    output logic             tick_nxt
);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    // >= rather than == so a shortened period never wraps through the full range.
    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (clr) begin
            div_d = '0;
        end else if (run) begin
            if (div_q >= (period - 1'b1)) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick     = tick_q;
    assign tick_nxt = tick_d;

endmodule

// File: rtl/tempo_tick.sv
// Tempo/transport generator driving the mod-4 beat counter's ena/inc/rst.
//   state | meaning
//   IDLE  | stopped, prescaler and sub-beat cleared
//   RUN   | prescaler counting, ticks emitted
//   PAUSE | frozen, prescaler and sub-beat held
module tempo_tick
    import mp_pkg::*;
#(
    parameter int BASE_PERIOD = 25000000,
    parameter int STEP_PERIOD = 2500000,
    parameter int DIV_W       = 25,
    parameter int SUBDIV      = 4,
    parameter int TEMPO_INIT  = 3
) (
    input  logic         clk,
    input  logic         rst,
    tempo_tick_if.slave  bus
);

    localparam int SUB_W = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;
    localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(SUBDIV - 1);
    localparam logic [TEMPO_W-1:0] TEMPO_TOP = TEMPO_W'(TEMPO_MAX);

    state_e             state_q, state_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic               inc_q, inc_d;
    logic               clr_q, clr_d;
    logic               playing_q, playing_d;
    logic [TEMPO_W-1:0] tempo_q, tempo_d;

    logic               run;
    logic               tick;
    logic               tick_nxt;
    logic [DIV_W-1:0]   period_w;

    assign period_w = DIV_W'(period(tempo_q, BASE_PERIOD, STEP_PERIOD));

    // Resuming from PAUSE counts on the play edge; starting from IDLE does not.
    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.play) state_d = RUN;
                RUN: begin
                    if (bus.pause) state_d = PAUSE;
                    else           run     = 1'b1;
                end
                PAUSE: begin
                    if (bus.play) begin
                        state_d = RUN;
                        run     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        playing_d = (state_d == RUN);
        clr_d     = bus.stop;
    end

    always_comb begin
        sub_d = sub_q;
        inc_d = 1'b0;
        if (bus.stop) begin
            sub_d = '0;
        end else if (tick_nxt) begin
            if (sub_q == SUB_LAST) begin
                sub_d = '0;
                inc_d = 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_comb begin
        tempo_d = tempo_q;
        if (bus.tempo_up && !bus.tempo_dn && (tempo_q != TEMPO_TOP)) begin
            tempo_d = tempo_q + 1'b1;
        end else if (bus.tempo_dn && !bus.tempo_up && (tempo_q != '0)) begin
            tempo_d = tempo_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sub_q     <= '0;
            inc_q     <= 1'b0;
            clr_q     <= 1'b0;
            playing_q <= 1'b0;
            tempo_q   <= TEMPO_W'(TEMPO_INIT);
        end else begin
            state_q   <= state_d;
            sub_q     <= sub_d;
            inc_q     <= inc_d;
            clr_q     <= clr_d;
            playing_q <= playing_d;
            tempo_q   <= tempo_d;
        end
    end

    tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .clr      (bus.stop),
        .period   (period_w),
        .tick     (tick),
        .tick_nxt (tick_nxt)
    );

    assign bus.ena     = tick;
    assign bus.inc     = inc_q;
    assign bus.cnt_clr = clr_q;
    assign bus.playing = playing_q;
    assign bus.tempo   = tempo_q;

endmodule

// File: tb/tb_tempo_tick.sv
// Randomized and directed bench for tempo_tick against a transport-level reference model.
module tb_tempo_tick;

    localparam int BASE   = 10;
    localparam int STEP   = 1;
    localparam int SUBDIV = 4;
    localparam int TINIT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tempo_tick_if bus ();

    tempo_tick #(
        .BASE_PERIOD (BASE),
        .STEP_PERIOD (STEP),
        .DIV_W       (25),
        .SUBDIV      (SUBDIV),
        .TEMPO_INIT  (TINIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 stopped, 1 playing, 2 paused.
    int m_mode, m_elapsed, m_ticks, m_tempo;
    bit m_ena, m_inc, m_clr, m_play;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0; m_ticks = 0; m_tempo = TINIT;
        m_ena = 0; m_inc = 0; m_clr = 0; m_play = 0;
    endtask

    task automatic model_advance(input int p);
        if (m_elapsed + 1 >= p) begin
            m_elapsed = 0;
            m_ticks++;
            m_ena = 1;
            m_inc = (m_ticks % SUBDIV) == 0;
        end else begin
            m_elapsed++;
        end
    endtask

    task automatic model_edge(input bit p, input bit pa, input bit s, input bit u, input bit d);
        int per;
        per   = BASE - m_tempo * STEP;
        m_ena = 0; m_inc = 0; m_clr = s;
        if (s) begin
            m_mode = 0; m_elapsed = 0; m_ticks = 0;
        end else if (m_mode == 0) begin
            if (p) m_mode = 1;
        end else if (m_mode == 1) begin
            if (pa) m_mode = 2;
            else    model_advance(per);
        end else if (p) begin
            m_mode = 1;
            model_advance(per);
        end
        if (u && !d && m_tempo < 7)      m_tempo++;
        else if (d && !u && m_tempo > 0) m_tempo--;
        m_play = (m_mode == 1);
    endtask

    task automatic check_all();
        chk("ena",     32'(bus.ena),     32'(m_ena));
        chk("inc",     32'(bus.inc),     32'(m_inc));
        chk("cnt_clr", 32'(bus.cnt_clr), 32'(m_clr));
        chk("playing", 32'(bus.playing), 32'(m_play));
        chk("tempo",   32'(bus.tempo),   32'(m_tempo));
    endtask

    task automatic step(input bit p, input bit pa, input bit s, input bit u, input bit d);
        bus.play = p; bus.pause = pa; bus.stop = s; bus.tempo_up = u; bus.tempo_dn = d;
        @(posedge clk);
        model_edge(p, pa, s, u, d);
        #1;
        bus.play = 0; bus.pause = 0; bus.stop = 0; bus.tempo_up = 0; bus.tempo_dn = 0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        int n_ena, n_inc, first, e1, e2, e3;
        bus.play = 0; bus.pause = 0; bus.stop = 0; bus.tempo_up = 0; bus.tempo_dn = 0;
        model_reset();
        #12;
        check_all();
        @(posedge clk);
        #1;
        rst = 1;

        // play at edge 0: ticks after edges 7,14,21,28, inc only with the 4th
        step(1, 0, 0, 0, 0);
        n_ena = 0; n_inc = 0;
        for (int k = 1; k <= 30; k++) begin
            step(0, 0, 0, 0, 0);
            n_ena += int'(bus.ena);
            n_inc += int'(bus.inc);
        end
        chk("ena_count_30", n_ena, 4);
        chk("inc_count_30", n_inc, 1);

        // pause at edge 10, play at edge 20: next tick after edge 24
        step(0, 0, 1, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0);
        idle(9);
        step(0, 1, 0, 0, 0);
        idle(9);
        step(1, 0, 0, 0, 0);
        first = -1;
        for (int k = 21; k <= 30; k++) begin
            step(0, 0, 0, 0, 0);
            if (bus.ena && first < 0) first = k;
        end
        chk("resume_edge", first, 24);

        // tempo saturation and simultaneous up/dn
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        chk("tempo_sat", 32'(bus.tempo), 7);
        step(0, 0, 0, 1, 1);
        chk("tempo_both", 32'(bus.tempo), 7);

        // shrink the period while div sits high
        do_reset();
        step(1, 0, 0, 0, 0);
        idle(6);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        e1 = -1; e2 = -1; e3 = -1;
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, 0, 0);
            if (bus.ena) begin
                if (e1 < 0) e1 = k; else if (e2 < 0) e2 = k; else if (e3 < 0) e3 = k;
            end
        end
        chk("fast_spacing", e3 - e2, 3);

        // stop and play together while running
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(3);
        step(1, 0, 1, 0, 0);
        chk("stop_play_clr", 32'(bus.cnt_clr), 1);
        chk("stop_play_run", 32'(bus.playing), 0);
        idle(12);

        // async reset right while a tick is showing
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 20 && !bus.ena; k++) step(0, 0, 0, 0, 0);
        chk("tick_before_rst", 32'(bus.ena), 1);
        #2;
        rst = 0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1;
        idle(20);

        // randomized transport and tempo traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(15) == 0, $urandom_range(31) == 0, $urandom_range(63) == 0,
                 $urandom_range(15) == 0, $urandom_range(15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
